// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration sequencer: FSM encoding,
// control-entry codes and millisecond timing helpers.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // Control entries carry an all-ones sub-address; the data byte selects end or delay.
  localparam logic [7:0] CMD_END       = 8'hF0;
  localparam logic [7:0] DELAY_STEP_MS = 8'd10;

  function automatic int ms_tick_cycles(input int clk_freq_hz);
    return (clk_freq_hz >= 1000) ? clk_freq_hz / 1000 : 1;
  endfunction

  // 8'hF1..8'hFF -> 10..150 ms; always fits in 8 bits.
  function automatic logic [7:0] delay_ms(input logic [7:0] code);
    return (code - CMD_END) * DELAY_STEP_MS;
  endfunction

endpackage

// File: rtl/sccb_cfg_sequencer_if.sv
// Handshake between the configuration sequencer (master) and the SCCB bus engine (slave).
interface sccb_cfg_sequencer_if #(
  parameter int SUB_W  = 8,
  parameter int DATA_W = 8
) ();
  logic              sccb_ready;
  logic              sccb_done;
  logic              sccb_nack;
  logic              sccb_start;
  logic [SUB_W-1:0]  sccb_sub_addr;
  logic [DATA_W-1:0] sccb_data;

  modport master (
    input  sccb_ready, sccb_done, sccb_nack,
    output sccb_start, sccb_sub_addr, sccb_data
  );

  modport slave (
    output sccb_ready, sccb_done, sccb_nack,
    input  sccb_start, sccb_sub_addr, sccb_data
  );
endinterface

// File: rtl/cfg_delay_timer.sv
// Millisecond delay timer: a ms prescaler feeding a down-counter, with a
// one-cycle expire pulse once the loaded number of milliseconds has elapsed.
module cfg_delay_timer
  import sccb_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] ms_i,
  output logic       expire_o
);
  localparam int TICK  = ms_tick_cycles(CLK_FREQ_HZ);
  localparam int PRE_W = $clog2(TICK + 1);

  logic [PRE_W-1:0] pre_q;
  logic [7:0]       ms_q;
  logic             run_q;
  logic             expire_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      ms_q     <= '0;
      run_q    <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (load_i) begin
        pre_q    <= '0;
        ms_q     <= ms_i;
        run_q    <= (ms_i != 8'd0);
        expire_q <= (ms_i == 8'd0);
      end else if (run_q) begin
        if (pre_q == PRE_W'(TICK - 1)) begin
          pre_q <= '0;
          if (ms_q == 8'd1) begin
            run_q    <= 1'b0;
            expire_q <= 1'b1;
          end else begin
            ms_q <= ms_q - 8'd1;
          end
        end else begin
          pre_q <= pre_q + PRE_W'(1);
        end
      end
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Camera register configuration sequencer: walks a synchronous command ROM and
// drives the SCCB master, with ms delays, NACK retry and a runaway-table guard.
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int ADDR_W      = 8,
  parameter int SUB_W       = 8,
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    config_start,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [SUB_W+DATA_W-1:0] rom_data,
  sccb_cfg_sequencer_if.master    sccb,
  output logic                    busy,
  output logic                    config_done,
  output logic                    config_err,
  output logic [ADDR_W-1:0]       err_index
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  seq_state_t         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [RETRY_W-1:0] retry_q;
  logic [GAP_W-1:0]   gap_q;
  logic               start_q;
  logic [SUB_W-1:0]   sub_q;
  logic [DATA_W-1:0]  data_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [ADDR_W-1:0]  err_idx_q;
  logic               tload_q;
  logic [7:0]         tms_q;
  logic               t_expire;

  logic [SUB_W-1:0]   rom_sub;
  logic [DATA_W-1:0]  rom_dat;
  logic               is_ctrl;
  logic               is_end;
  logic               is_delay;
  logic               last_addr;

  assign {rom_sub, rom_dat} = rom_data;
  assign is_ctrl   = &rom_sub;
  assign is_end    = is_ctrl && (rom_dat[7:0] == CMD_END);
  assign is_delay  = is_ctrl && !is_end && (rom_dat[7:4] == 4'hF);
  assign last_addr = (addr_q == '1);

  cfg_delay_timer #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tload_q),
    .ms_i     (tms_q),
    .expire_o (t_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      start_q   <= 1'b0;
      sub_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      tload_q   <= 1'b0;
      tms_q     <= '0;
    end else begin
      start_q <= 1'b0;
      tload_q <= 1'b0;
      // busy_q is low only in IDLE, DONE and ERROR, so a start request mid-table is dropped.
      if (config_start && !busy_q) begin
        state_q   <= ST_FETCH;
        addr_q    <= '0;
        retry_q   <= '0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        err_idx_q <= '0;
      end else begin
        unique case (state_q)
          ST_FETCH: state_q <= ST_DECODE;
          ST_DECODE: begin
            if (is_end) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (is_delay) begin
              state_q <= ST_DELAY;
              tload_q <= 1'b1;
              tms_q   <= delay_ms(rom_dat[7:0]);
            end else begin
              state_q <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (sccb.sccb_ready) begin
              start_q <= 1'b1;
              sub_q   <= rom_sub;
              data_q  <= rom_dat;
              state_q <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
            if (sccb.sccb_done) begin
              if (!sccb.sccb_nack) begin
                retry_q <= '0;
                if (last_addr) begin
                  state_q   <= ST_ERROR;
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  err_idx_q <= addr_q;
                end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  gap_q   <= '0;
                  state_q <= ST_GAP;
                end
              end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_q <= retry_q + RETRY_W'(1);
                state_q <= ST_ISSUE;
              end else begin
                state_q   <= ST_ERROR;
                busy_q    <= 1'b0;
                err_q     <= 1'b1;
                err_idx_q <= addr_q;
              end
            end
          end
          ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= ST_FETCH;
            else gap_q <= gap_q + GAP_W'(1);
          end
          ST_DELAY: begin
            if (t_expire) begin
              if (last_addr) begin
                state_q   <= ST_ERROR;
                busy_q    <= 1'b0;
                err_q     <= 1'b1;
                err_idx_q <= addr_q;
              end else begin
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= ST_FETCH;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign rom_addr           = addr_q;
  assign sccb.sccb_start    = start_q;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data     = data_q;
  assign busy               = busy_q;
  assign config_done        = done_q;
  assign config_err         = err_q;
  assign err_index          = err_idx_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: synchronous ROM model plus a behavioural
// SCCB slave with programmable NACK behaviour.
module tb_sccb_cfg_sequencer;
  localparam int ADDR_W    = 3;
  localparam int SLAVE_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        config_start;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy, config_done, config_err;
  logic [2:0]  err_index;

  logic [15:0] rom [0:7];
  int          cyc = 0;
  int          cs_cyc;
  int          passed = 0;
  int          total = 0;

  logic [7:0]  st_sub[$];
  logic [7:0]  st_dat[$];
  int          st_cyc[$];
  int          busy_cnt;
  logic [7:0]  cur_sub;
  int          nack_left = 0;
  bit          nack_sub_en = 1'b0;
  logic [7:0]  nack_sub = 8'h00;

  sccb_cfg_sequencer_if #(.SUB_W(8), .DATA_W(8)) sccb_bus ();

  sccb_cfg_sequencer #(
    .CLK_FREQ_HZ(100000), .ADDR_W(ADDR_W), .SUB_W(8), .DATA_W(8),
    .GAP_CYCLES(2), .MAX_RETRY(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .config_start (config_start),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sccb         (sccb_bus),
    .busy         (busy),
    .config_done  (config_done),
    .config_err   (config_err),
    .err_index    (err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Behavioural SCCB slave: takes a start, answers SLAVE_LAT cycles later.
  initial begin
    sccb_bus.sccb_ready = 1'b1;
    sccb_bus.sccb_done  = 1'b0;
    sccb_bus.sccb_nack  = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      sccb_bus.sccb_done = 1'b0;
      sccb_bus.sccb_nack = 1'b0;
      if (!rst) begin
        busy_cnt = 0;
        sccb_bus.sccb_ready = 1'b1;
      end else if (sccb_bus.sccb_start) begin
        st_sub.push_back(sccb_bus.sccb_sub_addr);
        st_dat.push_back(sccb_bus.sccb_data);
        st_cyc.push_back(cyc);
        cur_sub = sccb_bus.sccb_sub_addr;
        sccb_bus.sccb_ready = 1'b0;
        busy_cnt = SLAVE_LAT;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          sccb_bus.sccb_done  = 1'b1;
          sccb_bus.sccb_ready = 1'b1;
          if (nack_left > 0) begin
            sccb_bus.sccb_nack = 1'b1;
            nack_left--;
          end else if (nack_sub_en && cur_sub == nack_sub) begin
            sccb_bus.sccb_nack = 1'b1;
          end
        end
      end
    end
  end

  task automatic clear_log();
    st_sub = {};
    st_dat = {};
    st_cyc = {};
  endtask

  task automatic load_basic_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1280;
    rom[1] = 16'h1101;
    rom[2] = 16'hFFF0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    config_start = 1'b1;
    cs_cyc = cyc + 1;
    @(negedge clk);
    config_start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (config_done || config_err) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL %s_timeout: no done/err within %0d cycles", name, budget);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    config_start = 1'b0;
    load_basic_rom();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (config_done !== 1'b0) $display("FAIL reset_done: got %b want 0", config_done); else passed++;
    total++; if (config_err !== 1'b0) $display("FAIL reset_err: got %b want 0", config_err); else passed++;
    total++; if (err_index !== 3'd0) $display("FAIL reset_err_index: got %0d want 0", err_index); else passed++;
    total++; if (rom_addr !== 3'd0) $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); else passed++;
    total++; if (sccb_bus.sccb_start !== 1'b0) $display("FAIL reset_start: got %b want 0", sccb_bus.sccb_start); else passed++;
    total++; if ({sccb_bus.sccb_sub_addr, sccb_bus.sccb_data} !== 16'h0000)
      $display("FAIL reset_bus: got %h want 0000", {sccb_bus.sccb_sub_addr, sccb_bus.sccb_data}); else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic_rom();
    clear_log();
    pulse_start();
    wait_end("basic", 500);
    total++; if (st_sub.size() != 2) $display("FAIL basic_count: got %0d want 2", st_sub.size()); else passed++;
    total++; if (st_sub[0] !== 8'h12 || st_dat[0] !== 8'h80)
      $display("FAIL basic_w0: got %h_%h want 12_80", st_sub[0], st_dat[0]); else passed++;
    total++; if (st_sub[1] !== 8'h11 || st_dat[1] !== 8'h01)
      $display("FAIL basic_w1: got %h_%h want 11_01", st_sub[1], st_dat[1]); else passed++;
    total++; if (st_cyc[0] - cs_cyc != 3)
      $display("FAIL basic_latency: got %0d want 3", st_cyc[0] - cs_cyc); else passed++;
    total++; if (config_done !== 1'b1 || config_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_status: got done=%b err=%b busy=%b want 1 0 0", config_done, config_err, busy); else passed++;
  endtask

  task automatic test_nack_retry();
    load_basic_rom();
    clear_log();
    nack_left = 2;
    pulse_start();
    wait_end("retry", 500);
    total++; if (st_sub.size() != 4) $display("FAIL retry_count: got %0d want 4", st_sub.size()); else passed++;
    total++; if (st_sub[0] !== 8'h12 || st_sub[1] !== 8'h12 || st_sub[2] !== 8'h12 || st_dat[2] !== 8'h80)
      $display("FAIL retry_same_entry: got %h %h %h_%h want 12 12 12_80", st_sub[0], st_sub[1], st_sub[2], st_dat[2]); else passed++;
    total++; if (st_sub[3] !== 8'h11) $display("FAIL retry_next: got %h want 11", st_sub[3]); else passed++;
    total++; if (config_done !== 1'b1 || config_err !== 1'b0)
      $display("FAIL retry_status: got done=%b err=%b want 1 0", config_done, config_err); else passed++;
  endtask

  task automatic test_nack_exhaust();
    int n;
    load_basic_rom();
    clear_log();
    nack_left = 0;
    nack_sub = 8'h11;
    nack_sub_en = 1'b1;
    pulse_start();
    wait_end("exhaust", 500);
    n = st_sub.size();
    total++; if (n != 5) $display("FAIL exhaust_count: got %0d want 5", n); else passed++;
    total++; if (config_err !== 1'b1 || config_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL exhaust_status: got err=%b done=%b busy=%b want 1 0 0", config_err, config_done, busy); else passed++;
    total++; if (err_index !== 3'd1) $display("FAIL exhaust_err_index: got %0d want 1", err_index); else passed++;
    repeat (60) @(negedge clk);
    total++; if (st_sub.size() != n) $display("FAIL exhaust_quiet: got %0d starts want %0d", st_sub.size(), n); else passed++;
    nack_sub_en = 1'b0;
  endtask

  task automatic test_delay();
    int gap;
    load_basic_rom();
    rom[1] = 16'hFFF1;
    rom[2] = 16'h1101;
    rom[3] = 16'hFFF0;
    clear_log();
    pulse_start();
    total++; if (config_err !== 1'b0) $display("FAIL delay_err_cleared: got %b want 0", config_err); else passed++;
    repeat (300) @(negedge clk);
    pulse_start();
    wait_end("delay", 3000);
    gap = (st_cyc.size() >= 2) ? st_cyc[1] - st_cyc[0] : 0;
    total++; if (st_sub.size() != 2) $display("FAIL delay_count: got %0d want 2", st_sub.size()); else passed++;
    total++; if (gap < 1000 || gap > 1040) $display("FAIL delay_gap: got %0d want 1000..1040", gap); else passed++;
    total++; if (st_sub[1] !== 8'h11 || st_dat[1] !== 8'h01)
      $display("FAIL delay_w1: got %h_%h want 11_01", st_sub[1], st_dat[1]); else passed++;
    total++; if (config_done !== 1'b1 || config_err !== 1'b0)
      $display("FAIL delay_status: got done=%b err=%b want 1 0", config_done, config_err); else passed++;
  endtask

  task automatic test_runaway();
    for (int i = 0; i < 8; i++) rom[i] = {8'h20 + 8'(i), 8'h40 + 8'(i)};
    clear_log();
    pulse_start();
    wait_end("runaway", 800);
    total++; if (st_sub.size() != 8) $display("FAIL runaway_count: got %0d want 8", st_sub.size()); else passed++;
    total++; if (st_sub[7] !== 8'h27 || st_dat[7] !== 8'h47)
      $display("FAIL runaway_last: got %h_%h want 27_47", st_sub[7], st_dat[7]); else passed++;
    total++; if (config_err !== 1'b1 || config_done !== 1'b0)
      $display("FAIL runaway_status: got err=%b done=%b want 1 0", config_err, config_done); else passed++;
    total++; if (err_index !== 3'd7) $display("FAIL runaway_err_index: got %0d want 7", err_index); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    load_basic_rom();
    clear_log();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (st_sub.size() > 0) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) $display("FAIL midrst_first_start: no start within 50 cycles"); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || config_done !== 1'b0 || config_err !== 1'b0 || rom_addr !== 3'd0)
      $display("FAIL midrst_outputs: got busy=%b done=%b err=%b addr=%0d want 0 0 0 0", busy, config_done, config_err, rom_addr); else passed++;
    total++; if ({sccb_bus.sccb_start, sccb_bus.sccb_sub_addr, sccb_bus.sccb_data} !== 17'd0)
      $display("FAIL midrst_bus: got %b_%h_%h want 0", sccb_bus.sccb_start, sccb_bus.sccb_sub_addr, sccb_bus.sccb_data); else passed++;
    repeat (3) @(negedge clk);
    clear_log();
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (st_sub.size() != 0) $display("FAIL midrst_quiet: got %0d starts want 0", st_sub.size()); else passed++;
    pulse_start();
    wait_end("midrst", 500);
    total++; if (st_sub.size() != 2 || st_sub[0] !== 8'h12 || st_sub[1] !== 8'h11)
      $display("FAIL midrst_restart: got %0d starts first %h want 2 starts 12,11", st_sub.size(), st_sub[0]); else passed++;
    total++; if (config_done !== 1'b1) $display("FAIL midrst_done: got %b want 1", config_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nack_retry();
    test_nack_exhaust();
    test_delay();
    test_runaway();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
